// File: rtl/mem_arbiter_ctrl_if.sv
// Request, response and byte-wide RAM signals shared by the icache, the dcache
// and the external RAM port arbiter.
interface mem_arbiter_ctrl_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  i_req;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic                  i_flush;
   logic [31:0]           i_data;
   logic                  i_done;

   logic                  d_req;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic                  d_wr;
   logic [31:0]           d_wdata;
   logic [1:0]            d_size;
   logic [31:0]           d_rdata;
   logic                  d_rdone;
   logic                  d_wdone;

   logic [7:0]            mem_din;
   logic [7:0]            mem_dout;
   logic [ADDR_WIDTH-1:0] mem_a;
   logic                  mem_wr;

   // Requester/RAM side of the bus.
   modport master (
      output i_req, i_addr, i_flush, d_req, d_addr, d_wr, d_wdata, d_size, mem_din,
      input  i_data, i_done, d_rdata, d_rdone, d_wdone, mem_dout, mem_a, mem_wr
   );

   // Arbiter side of the bus.
   modport slave (
      input  i_req, i_addr, i_flush, d_req, d_addr, d_wr, d_wdata, d_size, mem_din,
      output i_data, i_done, d_rdata, d_rdone, d_wdone, mem_dout, mem_a, mem_wr
   );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// Arbitrates icache fetches and dcache accesses onto a byte-wide RAM port,
// splitting each 1/2/4-byte access into little-endian byte cycles.
module mem_arbiter_ctrl #(
   parameter int ADDR_WIDTH = 32
) (
   input logic              clk,
   input logic              rst,
   mem_arbiter_ctrl_if.slave bus
);

   typedef enum logic [2:0] {IDLE, IREAD, DREAD, DWRITE, DONE} state_t;

   state_t                state;
   logic [2:0]            cnt;
   logic [2:0]            nbytes;
   logic [ADDR_WIDTH-1:0] addr;
   logic [31:0]           wdata;
   logic [31:0]           rbuf;

   logic [2:0]            edge_idx;
   logic [1:0]            byte_sel;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [31:0]           cap_word;
   logic                  d_go;
   logic                  i_go;

   // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
   always_comb begin
      edge_idx  = cnt + 3'd1;
      byte_sel  = cnt[1:0] - 2'd1;
      next_addr = addr + ADDR_WIDTH'(edge_idx);
      cap_word  = rbuf;
      cap_word[{byte_sel, 3'b000} +: 8] = bus.mem_din;
      d_go      = bus.d_req && (bus.d_size != 2'b00);
      i_go      = bus.i_req && !bus.i_flush;
   end

   // NOTE: state and outputs use <= so every branch reads the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         nbytes       <= '0;
         addr         <= '0;
         wdata        <= '0;
         rbuf         <= '0;
         bus.i_data   <= '0;
         bus.i_done   <= 1'b0;
         bus.d_rdata  <= '0;
         bus.d_rdone  <= 1'b0;
         bus.d_wdone  <= 1'b0;
         bus.mem_a    <= '0;
         bus.mem_dout <= '0;
         bus.mem_wr   <= 1'b0;
      end else begin
         bus.i_done  <= 1'b0;
         bus.d_rdone <= 1'b0;
         bus.d_wdone <= 1'b0;
         case (state)
            IDLE: begin
               cnt  <= '0;
               rbuf <= '0;
               if (d_go) begin
                  addr      <= bus.d_addr;
                  wdata     <= bus.d_wdata;
                  nbytes    <= (bus.d_size == 2'b11) ? 3'd4 : {1'b0, bus.d_size};
                  bus.mem_a <= bus.d_addr;
                  if (bus.d_wr) begin
                     bus.mem_wr   <= 1'b1;
                     bus.mem_dout <= bus.d_wdata[7:0];
                     state        <= DWRITE;
                  end else begin
                     state <= DREAD;
                  end
               end else if (i_go) begin
                  addr      <= bus.i_addr;
                  nbytes    <= 3'd4;
                  bus.mem_a <= bus.i_addr;
                  state     <= IREAD;
               end
            end

            IREAD, DREAD: begin
               if (state == IREAD && bus.i_flush) begin
                  // Branch redirect: abandon the fetch, in-flight bytes are never captured.
                  bus.mem_a <= '0;
                  cnt       <= '0;
                  state     <= IDLE;
               end else begin
                  cnt       <= edge_idx;
                  bus.mem_a <= (edge_idx < nbytes) ? next_addr : '0;
                  if (edge_idx >= 3'd2)
                     rbuf <= cap_word;
                  if (edge_idx == nbytes + 3'd1) begin
                     cnt   <= '0;
                     state <= DONE;
                     if (state == IREAD) begin
                        bus.i_data <= cap_word;
                        bus.i_done <= 1'b1;
                     end else begin
                        bus.d_rdata <= cap_word;
                        bus.d_rdone <= 1'b1;
                     end
                  end
               end
            end

            DWRITE: begin
               if (edge_idx < nbytes) begin
                  cnt          <= edge_idx;
                  bus.mem_a    <= next_addr;
                  bus.mem_dout <= wdata[{edge_idx[1:0], 3'b000} +: 8];
                  bus.mem_wr   <= 1'b1;
               end else begin
                  cnt          <= '0;
                  bus.mem_a    <= '0;
                  bus.mem_dout <= '0;
                  bus.mem_wr   <= 1'b0;
                  bus.d_wdone  <= 1'b1;
                  state        <= DONE;
               end
            end

            // One dead cycle lets the requester refill and drop its request.
            DONE: begin
               cnt   <= '0;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
